// File: rtl/helper_axis_pkg.sv
// rtl/helper_axis_pkg.sv - shared types, constants and checksum step for helper_axis_drain
// Purpose : drain FSM state encoding, backpressure LFSR taps, rotate-left-xor checksum helper.
// Ports   : none (package).
package helper_axis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } drain_state_t;

   // Galois feedback mask for the 16-bit backpressure LFSR (right-shifting form).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Widest checksum the helper supports; callers cast down to their own width.
   localparam int CS_MAX = 64;
   localparam logic [CS_MAX-1:0] CS_ONE = {{(CS_MAX-1){1'b0}}, 1'b1};

   // One checksum fold: rotate cur left by one inside 'width' bits, then xor data.
   function automatic logic [CS_MAX-1:0] checksum_step(
      input logic [CS_MAX-1:0] cur,
      input logic [CS_MAX-1:0] data,
      input int unsigned       width
   );
      logic [CS_MAX-1:0] mask;
      logic [CS_MAX-1:0] rot;
      mask = (width >= CS_MAX) ? {CS_MAX{1'b1}} : ((CS_ONE << width) - CS_ONE);
      rot  = ((cur << 1) | (cur >> (width - 1))) & mask;
      return rot ^ (data & mask);
   endfunction

endpackage

// File: rtl/helper_lfsr16.sv
// rtl/helper_lfsr16.sv - 16-bit Galois LFSR with load and advance controls
// Purpose : pseudo-random source for the drain backpressure pattern.
// Ports   : clk, rst (async active-low), load (reload SEED), advance (step once),
//           state (current 16-bit LFSR value).
module helper_lfsr16
   import helper_axis_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else if (load) begin
         state <= SEED;
      end else if (advance) begin
         state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/helper_axis_drain.sv
// rtl/helper_axis_drain.sv - AXIS sink accepting a fixed beat count under LFSR backpressure
// Purpose : drains BEAT_COUNT beats, counts them, folds each into a rotate-xor checksum
//           and raises done when finished.
// Ports   : clk, rst (async active-low), enable (run / pause / re-arm after done),
//           input_valid, input_data (upstream stream), input_ready (registered ready),
//           beats (accepted count), checksum (running fold), done (run complete).
module helper_axis_drain
   import helper_axis_pkg::*;
#(
   parameter int          DATA_WIDTH  = 10,
   parameter int          BEAT_COUNT  = 256,
   parameter int          STALL_LEVEL = 0,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            input_valid,
   input  logic [DATA_WIDTH-1:0]           input_data,
   output logic                            input_ready,
   output logic [$clog2(BEAT_COUNT+1)-1:0] beats,
   output logic [DATA_WIDTH-1:0]           checksum,
   output logic                            done
);

   localparam int            BW        = $clog2(BEAT_COUNT + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEAT_COUNT - 1);
   localparam logic [7:0]    STALL_THR = 8'(STALL_LEVEL);

   drain_state_t state;
   drain_state_t state_next;
   logic [15:0]  lfsr;
   logic         hs;
   logic         last_hs;
   logic         start;
   logic         lfsr_adv;
   logic         pace_ok;
   logic         ready_next;

   assign hs      = input_valid & input_ready;
   assign last_hs = hs & (beats == LAST_BEAT);

   // A zero threshold never stalls; keeping it out of the compare avoids an always-true test.
   generate
      if (STALL_LEVEL == 0) begin : g_no_stall
         assign pace_ok = 1'b1;
      end else begin : g_stall
         assign pace_ok = (lfsr[7:0] >= STALL_THR);
      end
   endgenerate

   helper_lfsr16 #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .advance (lfsr_adv),
      .state   (lfsr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable)  state_next = RUN;
         RUN:     if (last_hs) state_next = DONE;
         DONE:    if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ready is computed one cycle ahead and dropped on the final handshake so the
   // beat count can never pass BEAT_COUNT.
   always_comb begin
      start      = 1'b0;
      lfsr_adv   = 1'b0;
      ready_next = 1'b0;
      case (state)
         IDLE: start = enable;
         RUN: begin
            lfsr_adv   = 1'b1;
            ready_next = enable & pace_ok & ~last_hs;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         input_ready <= 1'b0;
         done        <= 1'b0;
         beats       <= '0;
         checksum    <= '0;
      end else begin
         input_ready <= ready_next;
         if (start) begin
            beats    <= '0;
            checksum <= '0;
            done     <= 1'b0;
         end else if (hs && state == RUN) begin
            beats    <= beats + BW'(1);
            checksum <= DATA_WIDTH'(checksum_step(CS_MAX'(checksum), CS_MAX'(input_data),
                                                  DATA_WIDTH));
            if (last_hs) begin
               done <= 1'b1;
            end
         end
      end
   end

endmodule
